// File: rtl/lut_match_qualifier.sv
// Qualifies LUT matches that hold with a constant code for STABLE_CYC clocks, then counts and records them.
// Optional timestamping of each event is enabled by defining LUT_QUAL_TIMESTAMP_EN.
module lut_match_qualifier #(
  parameter int STABLE_CYC = 3,
  parameter int CNT_W      = 8,
  parameter int TS_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [3:0]       x_i,
  input  logic             y_i,
  output logic             evt_o,
  output logic [CNT_W-1:0] evt_cnt_o,
  output logic [3:0]       last_code_o,
  output logic             ovf_o,
`ifdef LUT_QUAL_TIMESTAMP_EN
  output logic [TS_W-1:0]  ts_o,
`endif
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    ACTIVE  = 2'd2
  } state_e;

  localparam logic [3:0] StableTgt = 4'(STABLE_CYC);

  if (STABLE_CYC < 1 || STABLE_CYC > 15) begin : g_bad_stable
    $error("lut_match_qualifier: STABLE_CYC must be in 1..15");
  end
  if (CNT_W < 1 || TS_W < 1) begin : g_bad_width
    $error("lut_match_qualifier: CNT_W and TS_W must be positive");
  end

  state_e           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       stab_q, stab_d;
  logic             fire;
  logic             evt_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       last_q;
  logic             ovf_q;
  logic             busy_q;

  // A candidate enters QUALIFY with count 1; reaching the target there converts straight to ACTIVE,
  // which also covers STABLE_CYC=1 for both fresh matches and code changes while ACTIVE.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    stab_d  = stab_q;
    fire    = 1'b0;
    if (clr_i || !en_i) begin
      state_d = IDLE;
      stab_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (y_i) begin
            cand_d  = x_i;
            stab_d  = 4'd1;
            state_d = QUALIFY;
          end
        end
        QUALIFY, ACTIVE: begin
          if (!y_i) begin
            state_d = IDLE;
            stab_d  = '0;
          end else if (x_i != cand_q) begin
            cand_d  = x_i;
            stab_d  = 4'd1;
            state_d = QUALIFY;
          end else if (state_q == QUALIFY) begin
            stab_d = stab_q + 4'd1;
          end
        end
        default: begin
          state_d = IDLE;
          stab_d  = '0;
        end
      endcase
      if (state_d == QUALIFY && stab_d == StableTgt) begin
        fire    = 1'b1;
        state_d = ACTIVE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cand_q  <= '0;
      stab_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      stab_q  <= stab_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // Clear wins over a coincident event; counter saturates and flags overflow instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q  <= 1'b0;
      cnt_q  <= '0;
      last_q <= '0;
      ovf_q  <= 1'b0;
    end else if (clr_i) begin
      evt_q  <= 1'b0;
      cnt_q  <= '0;
      last_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      evt_q <= fire;
      if (fire) begin
        last_q <= cand_d;
        if (&cnt_q) begin
          ovf_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

`ifdef LUT_QUAL_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt_q;
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= clr_i ? '0 : ts_cnt_q + TS_W'(1);
      if (fire && !clr_i) begin
        ts_q <= ts_cnt_q;
      end
    end
  end

  assign ts_o = ts_q;
`endif

  assign evt_o       = evt_q;
  assign evt_cnt_o   = cnt_q;
  assign last_code_o = last_q;
  assign ovf_o       = ovf_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_lut_match_qualifier.sv
// Self-checking bench for lut_match_qualifier: directed vector table, corner sequences and
// randomized traffic against a run-length reference model.
module tb_lut_match_qualifier;

  localparam int STABLE_CYC = 3;
  localparam int CNT_W      = 8;
  localparam int TS_W       = 16;

  logic             clk;
  logic             rst_n;
  logic             en_i;
  logic             clr_i;
  logic [3:0]       x_i;
  logic             y_i;
  logic             evt_o;
  logic [CNT_W-1:0] evt_cnt_o;
  logic [3:0]       last_code_o;
  logic             ovf_o;
  logic             busy_o;
`ifdef LUT_QUAL_TIMESTAMP_EN
  logic [TS_W-1:0]  ts_o;
`endif

  lut_match_qualifier #(
    .STABLE_CYC(STABLE_CYC),
    .CNT_W     (CNT_W),
    .TS_W      (TS_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en_i),
    .clr_i      (clr_i),
    .x_i        (x_i),
    .y_i        (y_i),
    .evt_o      (evt_o),
    .evt_cnt_o  (evt_cnt_o),
    .last_code_o(last_code_o),
    .ovf_o      (ovf_o),
`ifdef LUT_QUAL_TIMESTAMP_EN
    .ts_o       (ts_o),
`endif
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         en;
    bit         clr;
    bit         y;
    logic [3:0] x;
    bit         expEvt;
    int         expCnt;
    logic [3:0] expLast;
    bit         expBusy;
  } vec_t;

  vec_t tbl[$];
  int   nCompared;
  int   nMismatched;

  // Reference model: an event is the moment a run of enabled, uncleared y=1 samples with the
  // same code reaches exactly STABLE_CYC samples.
  int         mRun;
  logic [3:0] mPrevX;
  bit         mEvt;
  int         mCnt;
  bit         mOvf;
  logic [3:0] mLast;

  function automatic vec_t mk(bit en, bit clr, bit y, logic [3:0] x,
                              bit evt, int cnt, logic [3:0] last, bit busy);
    vec_t v;
    v.en = en; v.clr = clr; v.y = y; v.x = x;
    v.expEvt = evt; v.expCnt = cnt; v.expLast = last; v.expBusy = busy;
    return v;
  endfunction

  task automatic modelReset();
    mRun = 0; mPrevX = '0; mEvt = 0; mCnt = 0; mOvf = 0; mLast = '0;
  endtask

  task automatic modelStep(bit en, bit clr, bit y, logic [3:0] x);
    mEvt = 0;
    if (clr) begin
      mRun = 0; mCnt = 0; mOvf = 0; mLast = '0;
    end else if (!en || !y) begin
      mRun = 0;
    end else begin
      mRun   = (mRun > 0 && x == mPrevX) ? mRun + 1 : 1;
      mPrevX = x;
      if (mRun == STABLE_CYC) begin
        mEvt  = 1;
        mLast = x;
        if (mCnt == (1 << CNT_W) - 1) mOvf = 1;
        else mCnt = mCnt + 1;
      end
    end
  endtask

  task automatic applyStimulus(bit en, bit clr, bit y, logic [3:0] x);
    en_i = en; clr_i = clr; y_i = y; x_i = x;
    @(posedge clk);
    modelStep(en, clr, y, x);
    #1;
  endtask

  task automatic checkOutput(string name, int act, int exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic checkModel(string tag);
    checkOutput({tag, ".evt"},  int'(evt_o),       int'(mEvt));
    checkOutput({tag, ".cnt"},  int'(evt_cnt_o),   mCnt);
    checkOutput({tag, ".last"}, int'(last_code_o), int'(mLast));
    checkOutput({tag, ".ovf"},  int'(ovf_o),       int'(mOvf));
    checkOutput({tag, ".busy"}, int'(busy_o),      int'(mRun > 0));
  endtask

  initial begin
    nCompared = 0;
    nMismatched = 0;
    modelReset();
    rst_n = 1'b0; en_i = 1'b1; clr_i = 1'b0; y_i = 1'b0; x_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset.evt",  int'(evt_o),       0);
    checkOutput("reset.cnt",  int'(evt_cnt_o),   0);
    checkOutput("reset.last", int'(last_code_o), 0);
    checkOutput("reset.ovf",  int'(ovf_o),       0);
    checkOutput("reset.busy", int'(busy_o),      0);

    // Directed vectors: stable qualify, short pulse, code change, enable gating, change in ACTIVE.
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 0, 1, 4'hA, i == 2, i >= 2 ? 1 : 0, i >= 2 ? 4'hA : 4'h0, 1));
    tbl.push_back(mk(1, 0, 0, 4'hA, 0, 1, 4'hA, 0));
    tbl.push_back(mk(1, 0, 1, 4'h7, 0, 1, 4'hA, 1));
    tbl.push_back(mk(1, 0, 1, 4'h7, 0, 1, 4'hA, 1));
    tbl.push_back(mk(1, 0, 0, 4'h7, 0, 1, 4'hA, 0));
    tbl.push_back(mk(1, 0, 1, 4'h3, 0, 1, 4'hA, 1));
    tbl.push_back(mk(1, 0, 1, 4'h3, 0, 1, 4'hA, 1));
    tbl.push_back(mk(1, 0, 1, 4'h5, 0, 1, 4'hA, 1));
    tbl.push_back(mk(1, 0, 1, 4'h5, 0, 1, 4'hA, 1));
    tbl.push_back(mk(1, 0, 1, 4'h5, 1, 2, 4'h5, 1));
    tbl.push_back(mk(1, 0, 0, 4'h5, 0, 2, 4'h5, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 1, 4'h9, 0, 2, 4'h5, 0));
    tbl.push_back(mk(1, 0, 1, 4'h9, 0, 2, 4'h5, 1));
    tbl.push_back(mk(1, 0, 1, 4'h9, 0, 2, 4'h5, 1));
    tbl.push_back(mk(1, 0, 1, 4'h9, 1, 3, 4'h9, 1));
    tbl.push_back(mk(1, 0, 1, 4'h2, 0, 3, 4'h9, 1));
    tbl.push_back(mk(1, 0, 1, 4'h2, 0, 3, 4'h9, 1));
    tbl.push_back(mk(1, 0, 1, 4'h2, 1, 4, 4'h2, 1));
    tbl.push_back(mk(0, 0, 1, 4'h2, 0, 4, 4'h2, 0));
    tbl.push_back(mk(1, 0, 0, 4'h0, 0, 4, 4'h2, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].en, tbl[i].clr, tbl[i].y, tbl[i].x);
      checkOutput($sformatf("vec%0d.evt", i),  int'(evt_o),       int'(tbl[i].expEvt));
      checkOutput($sformatf("vec%0d.cnt", i),  int'(evt_cnt_o),   tbl[i].expCnt);
      checkOutput($sformatf("vec%0d.last", i), int'(last_code_o), int'(tbl[i].expLast));
      checkOutput($sformatf("vec%0d.ovf", i),  int'(ovf_o),       0);
      checkOutput($sformatf("vec%0d.busy", i), int'(busy_o),      int'(tbl[i].expBusy));
    end

    // Saturation: 4 events so far, 251 more reach all-ones, one more sets overflow.
    for (int e = 0; e < 252; e++) begin
      for (int c = 0; c < STABLE_CYC; c++) applyStimulus(1, 0, 1, 4'hB);
      applyStimulus(1, 0, 0, 4'hB);
    end
    checkOutput("sat.cnt", int'(evt_cnt_o), 255);
    checkOutput("sat.ovf", int'(ovf_o),     1);
    checkOutput("sat.last", int'(last_code_o), 11);

    // Clear coinciding with what would be the qualifying edge.
    applyStimulus(1, 0, 1, 4'hE);
    applyStimulus(1, 0, 1, 4'hE);
    applyStimulus(1, 1, 1, 4'hE);
    checkOutput("clr.evt",  int'(evt_o),       0);
    checkOutput("clr.cnt",  int'(evt_cnt_o),   0);
    checkOutput("clr.ovf",  int'(ovf_o),       0);
    checkOutput("clr.last", int'(last_code_o), 0);
    checkOutput("clr.busy", int'(busy_o),      0);
    applyStimulus(1, 0, 1, 4'hE);
    checkOutput("postclr.evt",  int'(evt_o),  0);
    checkOutput("postclr.busy", int'(busy_o), 1);
    applyStimulus(1, 0, 0, 4'h0);

    // Randomized traffic against the model.
    begin
      logic [3:0] rx;
      rx = 4'h1;
      for (int n = 0; n < 600; n++) begin
        bit ren, rclr, ry;
        ren  = ($urandom % 16) != 0;
        rclr = ($urandom % 64) == 0;
        ry   = ($urandom % 6) != 0;
        if (($urandom % 5) == 0) rx = 4'($urandom % 16);
        applyStimulus(ren, rclr, ry, rx);
        checkModel($sformatf("rnd%0d", n));
      end
    end

    // Asynchronous reset mid-QUALIFY after making sure the outputs hold non-zero values.
    for (int c = 0; c < STABLE_CYC; c++) applyStimulus(1, 0, 1, 4'hC);
    applyStimulus(1, 0, 0, 4'hC);
    applyStimulus(1, 0, 1, 4'h4);
    applyStimulus(1, 0, 1, 4'h4);
    checkOutput("premid.busy", int'(busy_o),      1);
    checkOutput("premid.last", int'(last_code_o), 12);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("midrst.evt",  int'(evt_o),       0);
    checkOutput("midrst.cnt",  int'(evt_cnt_o),   0);
    checkOutput("midrst.last", int'(last_code_o), 0);
    checkOutput("midrst.ovf",  int'(ovf_o),       0);
    checkOutput("midrst.busy", int'(busy_o),      0);
    y_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkModel("rel");

    // Event fired on the 11th edge after release: timestamp counter holds 10 at that edge.
    for (int c = 0; c < 8; c++) applyStimulus(1, 0, 0, 4'h6);
    for (int c = 0; c < STABLE_CYC; c++) applyStimulus(1, 0, 1, 4'h6);
    checkModel("tsevt");
    checkOutput("tsevt.evt", int'(evt_o), 1);
`ifdef LUT_QUAL_TIMESTAMP_EN
    checkOutput("tsevt.ts", int'(ts_o), 10);
`endif
    applyStimulus(1, 0, 0, 4'h0);
    checkModel("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/lut_match_qualifier.md
Name: lut_match_qualifier

Overview:
- Downstream consumer of the 4-bit pattern LUT (x -> y).
- Samples the LUT output y together with the code x that produced it.
- Qualifies a match only when y stays high with an unchanged x for STABLE_CYC consecutive clocks, then records it: counts qualified events, latches the matching code and emits a one-cycle event pulse.
- Sits between the LUT and the status/readout logic.

Parameters:
- STABLE_CYC, 3, consecutive sampled cycles with y=1 and constant x required to qualify an event; legal range 1..15.
- CNT_W, 8, width of the saturating event counter.
- TS_W, 16, timestamp width; used only with the optional feature.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en_i  in  1  qualifier enable; low forces IDLE, counters hold.
- clr_i  in  1  synchronous clear of counter, overflow, last code and FSM.
- x_i  in  4  LUT input code, sampled alongside y_i.
- y_i  in  1  LUT match output.
- evt_o  out  1  one-cycle pulse per qualified event.
- evt_cnt_o  out  CNT_W  number of qualified events, saturating.
- last_code_o  out  4  x value of the most recent qualified event.
- ovf_o  out  1  sticky; set when an event arrives while evt_cnt_o is all-ones.
- busy_o  out  1  high in QUALIFY or ACTIVE.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, stable counter=0, evt_o=0, evt_cnt_o=0, last_code_o=0, ovf_o=0, busy_o=0.
- FSM states: IDLE, QUALIFY, ACTIVE. All outputs are registered.
- IDLE:
  - y_i=1: latch x_i into cand_code, stable count=1.
  - If STABLE_CYC=1, fire the event and go to ACTIVE; else go to QUALIFY.
- QUALIFY:
  - y_i=0: go to IDLE, no event.
  - y_i=1 and x_i≠cand_code: re-latch cand_code, count=1, stay in QUALIFY.
  - y_i=1 and x_i=cand_code: count++. When count reaches STABLE_CYC, fire the event and go to ACTIVE.
- ACTIVE:
  - Stay while y_i=1; go to IDLE on y_i=0.
  - x_i changes with y_i still 1: go to QUALIFY with the new cand_code and count=1. A new code is a new event candidate.
- Fire event, all in the same edge:
  - evt_o=1 for exactly one cycle.
  - last_code_o<=cand_code.
  - If evt_cnt_o < max, increment it; else hold it at all-ones and set ovf_o.
- Latency: with y_i high and x_i stable from sampled edge 1, evt_o is high in the cycle after edge STABLE_CYC.
- en_i=0: next state is IDLE, no event fires, evt_cnt_o, last_code_o and ovf_o hold.
- clr_i=1: evt_cnt_o=0, ovf_o=0, last_code_o=0, FSM=IDLE, evt_o=0. clr_i has priority over a simultaneous event and over en_i.
- ovf_o clears only on clr_i or reset.
- Reset asserted mid-QUALIFY or mid-ACTIVE: immediate return to the reset values; no partial event.

Optional Feature:
- Macro LUT_QUAL_TIMESTAMP_EN.
- Defined:
  - Adds a free-running TS_W-bit counter that wraps to 0 after all-ones; reset and clr_i set it to 0.
  - Adds output ts_o [TS_W-1:0], which latches the counter value on each fired event; reset value 0.
- Not defined: no timestamp counter, no ts_o port, and TS_W is unused.

Test Plan (STABLE_CYC=3, CNT_W=8):
- Reset, then y_i=1 with x_i=4'hA held 5 cycles -> evt_o pulses once, in the cycle after the 3rd sampled edge; evt_cnt_o=1; last_code_o=4'hA; busy_o stays high until y_i falls.
- y_i=1 for 2 cycles then 0 -> no evt_o; evt_cnt_o unchanged; FSM back in IDLE.
- y_i=1 held with x_i=4'h3 for 2 cycles, then x_i=4'h5 for 3 cycles -> exactly one event; last_code_o=4'h5.
- 256 qualified events -> evt_cnt_o=8'hFF, ovf_o=1; then clr_i=1 in the same cycle as a qualifying edge -> evt_cnt_o=0, ovf_o=0, evt_o=0.
- en_i=0 while y_i=1 is held stable -> no events; raise en_i -> event 3 cycles later.
- rst_n pulsed low asynchronously mid-QUALIFY -> all outputs 0 immediately. With LUT_QUAL_TIMESTAMP_EN defined, an event fired 10 cycles after reset release -> ts_o=10.
